gated_delay_pipe: RTL and testbench
===================================

Name: gated_delay_pipe

Overview:
- Parametrised successor to the single-bit enable-gated delay register.
- Elastic pipeline: WIDTH-bit data, DEPTH register stages, valid/ready handshake on both sides.
- Enable gating per beat: en=0 at accept stores CLR_VAL instead of the input data.
- Adds flush, occupancy reporting and optional statistics counters. Used wherever a gated delay line must tolerate downstream back-pressure.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 2, number of register stages, which is also the minimum latency in cycles (>=1)
- CLR_VAL, 0, value stored for a beat accepted with en=0, and the reset value of stage data
- OCC_W, $clog2(DEPTH+1), width of the occupancy output

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  sampled with each accepted beat; 1 stores in_data, 0 stores CLR_VAL
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  upstream beat valid
- in_ready  out  1  pipeline can accept this cycle
- in_data  in  WIDTH  upstream data
- out_valid  out  1  final stage holds a beat
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  final stage data
- occupancy  out  OCC_W  number of valid stages, 0..DEPTH
- stat_in  out  16  beats accepted (optional feature)
- stat_out  out  16  beats delivered (optional feature)
- stat_stall  out  16  cycles with out_valid=1 and out_ready=0 (optional feature)
- stat_zero  out  16  beats accepted with en=0 (optional feature)

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear; all stage data = CLR_VAL.
  - out_valid=0, out_data=CLR_VAL, occupancy=0, all stat_* = 0.
  - in_ready is combinational and reads 1 while reset is asserted, but no handshake is recorded during reset.
- Stages are indexed 0 (input) to DEPTH-1 (output). Each stage holds v[i] and d[i].
- Advance rule (ready propagates combinationally from the output back to the input):
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready
  - adv[i] = ~v[i] | adv[i+1]
- Stage i loads from stage i-1 (stage 0 loads from the input) when adv[i]=1.
  - If adv[i]=1 and the upstream side has no beat, v[i] clears (bubble).
  - If adv[i]=0, the stage holds its contents.
- in_ready = adv[0] & ~flush.
- Handshakes: an input beat is accepted when in_valid & in_ready; an output beat is delivered when out_valid & out_ready.
- Stored data at accept: en ? in_data : CLR_VAL. en is sampled only on the accept cycle.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1 when the path is unstalled. Throughput is 1 beat per cycle with out_ready held high.
- Back-pressure: out_ready=0 holds the output stage, and upstream stages compress into bubbles. Beats are never lost or duplicated, and order is preserved.
- Full: all v=1 and out_ready=0 gives in_ready=0. Full with out_ready=1 still gives in_ready=1 (pass-through shift).
- Empty: out_valid=0; out_ready is ignored.
- Flush: at the next edge all v clear and data is untouched. Flush wins over a simultaneous accept (in_ready is already 0) and over a simultaneous delivery. A delivery in the flush cycle still counts as delivered if out_ready=1, because that handshake is a combinational fact of the cycle.
- occupancy: registered population count of v, updated every edge.
- Reset mid-operation discards all beats immediately and asynchronously.

Optional Feature:
- Macro: GATED_DELAY_PIPE_STATS_EN.
- Defined: four 16-bit saturating counters (they stick at 0xFFFF).
  - stat_in counts accepts; stat_out counts deliveries.
  - stat_stall counts cycles with out_valid & ~out_ready.
  - stat_zero counts accepts with en=0.
  - Flush does not clear the counters; reset does.
- Not defined: stat_* ports remain present and are tied to 0, and no counter logic is instantiated.

Decomposition:
- Package gdp_pkg:
  - STAT_W=16 constant
  - stage record typedef (valid + data, parametrised via the module)
  - saturating-increment function
- Sub-module gdp_stage: one elastic register stage with inputs up_v, up_d, adv, flush and outputs v, d. It is instantiated DEPTH times in a generate loop. The top level computes the adv chain, the en gating, occupancy and the stats.

Test Plan:
- Reset then stream, DEPTH=2, WIDTH=8, en=1, out_ready=1: inputs 0x11,0x22,0x33 on consecutive cycles -> out_data is 0x11,0x22,0x33 on consecutive cycles, 2 cycles after each accept. occupancy is 2 at steady state.
- en gating: accept 0xAA (en=1), 0xBB (en=0), 0xCC (en=1) -> outputs 0xAA, CLR_VAL(0x00), 0xCC. With stats enabled, stat_zero=1.
- Back-pressure, DEPTH=3: hold out_ready=0 while pushing 5 beats -> in_ready falls after 3 accepts and occupancy=3. Release out_ready -> all 5 beats are delivered in order with none lost. stat_stall equals the number of stalled cycles.
- Flush while full, coincident with in_valid=1: in_ready=0 that cycle. Next cycle occupancy=0 and out_valid=0. A subsequent beat takes DEPTH cycles to reach the output.
- Async reset asserted mid-stream, between clock edges -> out_valid and occupancy drop to 0 before the next edge. After release, the pipeline accepts normally.
- Saturation: with stats enabled, force 70000 accepts -> stat_in=0xFFFF.

Source files
------------

// File: rtl/gdp_pkg.sv
// gdp_pkg
//   Shared constants and helpers for the gated delay pipe.
//   STAT_W   : width of every statistics counter
//   stat_t   : statistics counter type
//   sat_inc  : increment that sticks at all-ones
// The per-stage record (valid + data) depends on the pipe's WIDTH, so it is
// declared inside gdp_stage where that parameter is in scope.
package gdp_pkg;

   localparam int STAT_W = 16;

   typedef logic [STAT_W-1:0] stat_t;

   function automatic stat_t sat_inc(input stat_t cnt, input logic inc);
      if (inc && (cnt != '1)) begin
         return cnt + stat_t'(1);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/gdp_stage.sv
// gdp_stage
//   One elastic register stage of the gated delay pipe.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     up_v/up_d : beat offered by the upstream side (previous stage or input)
//     adv       : this stage may load this cycle (downstream has room)
//     flush     : clear the valid bit at the next edge, data untouched
//     v/d       : stage contents
module gdp_stage
   import gdp_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_v,
   input  logic [WIDTH-1:0] up_d,
   input  logic             adv,
   input  logic             flush,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] d;
   } stage_t;

   stage_t stage_q, stage_d;

   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         // flush beats an advance: the beat is dropped, data left in place
         stage_d.v = 1'b0;
      end else if (adv) begin
         stage_d.v = up_v;
         stage_d.d = up_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '{v: 1'b0, d: CLR_VAL};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign v = stage_q.v;
   assign d = stage_q.d;

endmodule

// File: rtl/gated_delay_pipe.sv
// gated_delay_pipe
//   Elastic DEPTH-stage delay line with per-beat enable gating: a beat
//   accepted with en=0 is stored as CLR_VAL. Valid/ready on both sides,
//   synchronous flush, registered occupancy.
//   Optional statistics counters: define GATED_DELAY_PIPE_STATS_EN.
//   Without it the stat_* ports are tied to zero.
//   Ports:
//     clk, rst               : clock, asynchronous active-high reset
//     en                     : 1 stores in_data, 0 stores CLR_VAL (accept cycle)
//     flush                  : drop every beat at the next edge
//     in_valid/in_ready/in_data    : upstream handshake
//     out_valid/out_ready/out_data : downstream handshake
//     occupancy              : number of valid stages
//     stat_in/out/stall/zero : accepts, deliveries, stalled cycles, en=0 accepts
module gated_delay_pipe
   import gdp_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] CLR_VAL = '0,
   parameter int               OCC_W   = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [OCC_W-1:0]  occupancy,
   output logic [STAT_W-1:0] stat_in,
   output logic [STAT_W-1:0] stat_out,
   output logic [STAT_W-1:0] stat_stall,
   output logic [STAT_W-1:0] stat_zero
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] up_v;
   logic [DEPTH-1:0] v_nxt;
   logic [WIDTH-1:0] d    [DEPTH];
   logic [WIDTH-1:0] up_d [DEPTH];
   logic             accept;
   logic [OCC_W-1:0] occ_q, occ_d;

   // Ready ripples from the output back to the input: a stage can load if
   // it is empty or the stage after it is moving.
   always_comb begin
      logic chain;
      adv   = '0;
      chain = out_ready;
      for (int i = DEPTH-1; i >= 0; i--) begin
         adv[i] = ~v[i] | chain;
         chain  = adv[i];
      end
   end

   assign in_ready  = adv[0] & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   always_comb begin
      up_v    = '0;
      up_v[0] = accept;
      up_d[0] = en ? in_data : CLR_VAL;
      for (int i = 1; i < DEPTH; i++) begin
         up_v[i] = v[i-1];
         up_d[i] = d[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      gdp_stage #(
         .WIDTH   (WIDTH),
         .CLR_VAL (CLR_VAL)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .up_v  (up_v[g]),
         .up_d  (up_d[g]),
         .adv   (adv[g]),
         .flush (flush),
         .v     (v[g]),
         .d     (d[g])
      );
   end

   // Occupancy is counted from the valid bits the stages will hold after
   // this edge, so the registered value always matches the stages.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_nxt[i] = flush ? 1'b0 : (adv[i] ? up_v[i] : v[i]);
         occ_d    = occ_d + OCC_W'(v_nxt[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

`ifdef GATED_DELAY_PIPE_STATS_EN
   logic  deliver;
   stat_t stat_in_q, stat_in_d;
   stat_t stat_out_q, stat_out_d;
   stat_t stat_stall_q, stat_stall_d;
   stat_t stat_zero_q, stat_zero_d;

   // A delivery during flush still counts: the handshake happened this cycle.
   assign deliver = out_valid & out_ready;

   always_comb begin
      stat_in_d    = sat_inc(stat_in_q, accept);
      stat_out_d   = sat_inc(stat_out_q, deliver);
      stat_stall_d = sat_inc(stat_stall_q, out_valid & ~out_ready);
      stat_zero_d  = sat_inc(stat_zero_q, accept & ~en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_in_q    <= '0;
         stat_out_q   <= '0;
         stat_stall_q <= '0;
         stat_zero_q  <= '0;
      end else begin
         stat_in_q    <= stat_in_d;
         stat_out_q   <= stat_out_d;
         stat_stall_q <= stat_stall_d;
         stat_zero_q  <= stat_zero_d;
      end
   end

   assign stat_in    = stat_in_q;
   assign stat_out   = stat_out_q;
   assign stat_stall = stat_stall_q;
   assign stat_zero  = stat_zero_q;
`else
   assign stat_in    = '0;
   assign stat_out   = '0;
   assign stat_stall = '0;
   assign stat_zero  = '0;
`endif

endmodule

// File: tb/tb_gated_delay_pipe.sv
// tb_gated_delay_pipe
//   Directed bench for gated_delay_pipe. Two instances share the input
//   stimulus: u_a (DEPTH=2) and u_b (DEPTH=3). Each scenario resets first
//   and checks only the instance it targets.
module tb_gated_delay_pipe;

   logic clk = 1'b0;
   logic rst;
   logic en, flush, in_valid, out_ready;
   logic [7:0] in_data;

   logic        a_in_ready, a_out_valid;
   logic [7:0]  a_out_data;
   logic [1:0]  a_occ;
   logic [15:0] a_stat_in, a_stat_out, a_stat_stall, a_stat_zero;

   logic        b_in_ready, b_out_valid;
   logic [7:0]  b_out_data;
   logic [1:0]  b_occ;
   logic [15:0] b_stat_in, b_stat_out, b_stat_stall, b_stat_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gated_delay_pipe #(.WIDTH(8), .DEPTH(2)) u_a (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .occupancy(a_occ),
      .stat_in(a_stat_in), .stat_out(a_stat_out),
      .stat_stall(a_stat_stall), .stat_zero(a_stat_zero)
   );

   gated_delay_pipe #(.WIDTH(8), .DEPTH(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .occupancy(b_occ),
      .stat_in(b_stat_in), .stat_out(b_stat_out),
      .stat_stall(b_stat_stall), .stat_zero(b_stat_zero)
   );

   task automatic idle_inputs();
      en        = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = 8'h00;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", a_out_valid); end
      checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", a_occ); end
      checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", a_out_data); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", a_in_ready); end
      checks++; if ({a_stat_in, a_stat_out, a_stat_stall, a_stat_zero} !== 64'h0) begin errors++; $display("FAIL rst_stats got %h %h %h %h exp 0", a_stat_in, a_stat_out, a_stat_stall, a_stat_zero); end
      // no handshake is recorded while reset is held
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_accept got occ %0d valid %0b exp 0 0", b_occ, b_out_valid); end
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      logic [7:0] din [3];
      logic       ev  [5];
      logic [7:0] ed  [5];
      logic [1:0] eo  [5];
      din = '{8'h11, 8'h22, 8'h33};
      ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ed  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      eo  = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            in_valid = 1'b1;
            in_data  = din[k];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (k == 2) begin
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_full_passthrough got %0b exp 1", a_in_ready); end
         end
         @(posedge clk); #1;
         checks++; if (a_out_valid !== ev[k]) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp %0b", k, a_out_valid, ev[k]); end
         if (ev[k]) begin
            checks++; if (a_out_data !== ed[k]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", k, a_out_data, ed[k]); end
         end
         checks++; if (a_occ !== eo[k]) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp %0d", k, a_occ, eo[k]); end
      end
   endtask

   task automatic test_en_gating();
      logic [7:0] din [3];
      logic       een [3];
      logic [7:0] ed  [5];
      din = '{8'hAA, 8'hBB, 8'hCC};
      een = '{1'b1, 1'b0, 1'b1};
      ed  = '{8'h00, 8'hAA, 8'h00, 8'hCC, 8'h00};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin
            in_valid = 1'b1;
            in_data  = din[k];
            en       = een[k];
         end else begin
            in_valid = 1'b0;
            en       = 1'b1;
         end
         @(posedge clk); #1;
         if (k >= 1 && k <= 3) begin
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== ed[k]) begin errors++; $display("FAIL gate_data[%0d] got %0b/%h exp 1/%h", k, a_out_valid, a_out_data, ed[k]); end
         end
      end
`ifdef GATED_DELAY_PIPE_STATS_EN
      checks++; if (a_stat_zero !== 16'd1) begin errors++; $display("FAIL gate_stat_zero got %0d exp 1", a_stat_zero); end
      checks++; if (a_stat_in !== 16'd3 || a_stat_out !== 16'd3) begin errors++; $display("FAIL gate_stat_inout got %0d/%0d exp 3/3", a_stat_in, a_stat_out); end
`else
      checks++; if (a_stat_zero !== 16'd0 || a_stat_in !== 16'd0) begin errors++; $display("FAIL gate_stat_tied got %0d/%0d exp 0/0", a_stat_zero, a_stat_in); end
`endif
   endtask

   task automatic test_back_pressure();
      int sent = 0;
      int got  = 0;
      do_reset();
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid  = (sent < 5);
         in_data   = 8'(sent + 1);
         out_ready = (cyc >= 5);
         #1;
         if (cyc < 5) begin
            checks++; if (b_in_ready !== (cyc < 3)) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp %0b", cyc, b_in_ready, (cyc < 3)); end
         end
         if (cyc == 3) begin
            checks++; if (b_occ !== 2'd3) begin errors++; $display("FAIL bp_occ_full got %0d exp 3", b_occ); end
         end
         if (in_valid && b_in_ready) sent++;
         if (b_out_valid && out_ready) begin
            checks++; if (b_out_data !== 8'(got + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", got, b_out_data, 8'(got + 1)); end
            got++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (got != 5) begin errors++; $display("FAIL bp_delivered got %0d exp 5", got); end
      checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL bp_drained got %0d exp 0", b_occ); end
`ifdef GATED_DELAY_PIPE_STATS_EN
      checks++; if (b_stat_stall !== 16'd2) begin errors++; $display("FAIL bp_stat_stall got %0d exp 2", b_stat_stall); end
      checks++; if (b_stat_in !== 16'd5 || b_stat_out !== 16'd5) begin errors++; $display("FAIL bp_stat_inout got %0d/%0d exp 5/5", b_stat_in, b_stat_out); end
`else
      checks++; if (b_stat_stall !== 16'd0) begin errors++; $display("FAIL bp_stat_tied got %0d exp 0", b_stat_stall); end
`endif
   endtask

   task automatic test_flush();
      int lat = 0;
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h31 + i);
         @(posedge clk); #1;
      end
      checks++; if (b_occ !== 2'd3) begin errors++; $display("FAIL flush_prefill got %0d exp 3", b_occ); end
      flush     = 1'b1;
      in_data   = 8'hEE;
      out_ready = 1'b1;
      #1;
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", b_in_ready); end
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared got occ %0d valid %0b exp 0 0", b_occ, b_out_valid); end
`ifdef GATED_DELAY_PIPE_STATS_EN
      checks++; if (b_stat_in !== 16'd3 || b_stat_out !== 16'd1) begin errors++; $display("FAIL flush_stats got %0d/%0d exp 3/1", b_stat_in, b_stat_out); end
`endif
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (b_out_valid) begin
            lat = n;
            break;
         end
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL flush_latency got %0d exp 3", lat); end
      checks++; if (b_out_data !== 8'h5A) begin errors++; $display("FAIL flush_next_data got %h exp 5a", b_out_data); end
   endtask

   task automatic test_async_reset();
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'h41;
      @(posedge clk); #1;
      in_data  = 8'h42;
      @(posedge clk); #1;
      checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got %0d exp 2", a_occ); end
      #1;
      rst = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin errors++; $display("FAIL areset_immediate got valid %0b occ %0d exp 0 0", a_out_valid, a_occ); end
      checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL areset_b_occ got %0d exp 0", b_occ); end
      rst      = 1'b0;
      in_data  = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL areset_reaccept got %0d exp 1", a_occ); end
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h77) begin errors++; $display("FAIL areset_out got %0b/%h exp 1/77", a_out_valid, a_out_data); end
   endtask

   task automatic test_stats();
      do_reset();
`ifdef GATED_DELAY_PIPE_STATS_EN
      in_valid  = 1'b1;
      out_ready = 1'b1;
      en        = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if (a_stat_in !== 16'hFFFF || b_stat_in !== 16'hFFFF) begin errors++; $display("FAIL sat_stat_in got %h/%h exp ffff", a_stat_in, b_stat_in); end
      checks++; if (a_stat_out !== 16'hFFFF) begin errors++; $display("FAIL sat_stat_out got %h exp ffff", a_stat_out); end
      checks++; if (a_stat_zero !== 16'h0 || a_stat_stall !== 16'h0) begin errors++; $display("FAIL sat_others got %h/%h exp 0/0", a_stat_zero, a_stat_stall); end
`else
      in_valid  = 1'b1;
      out_ready = 1'b0;
      en        = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      in_valid = 1'b0;
      en       = 1'b1;
      checks++; if ({a_stat_in, a_stat_out, a_stat_stall, a_stat_zero} !== 64'h0) begin errors++; $display("FAIL stats_tied_a got %h %h %h %h exp 0", a_stat_in, a_stat_out, a_stat_stall, a_stat_zero); end
      checks++; if ({b_stat_in, b_stat_out, b_stat_stall, b_stat_zero} !== 64'h0) begin errors++; $display("FAIL stats_tied_b got %h %h %h %h exp 0", b_stat_in, b_stat_out, b_stat_stall, b_stat_zero); end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_en_gating();
      test_back_pressure();
      test_flush();
      test_async_reset();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
